// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: autonomous conv-flow sequencer driving the 34-bit core instruction word.
// Optional SEQ_OFIFO_HANDSHAKE_EN gates OFRD transfers on ofifo_valid.
module core_inst_sequencer #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int k        = 3,
    parameter int in_w     = 6,
    parameter int nw       = 2 * col,
    parameter int na       = 2 * in_w * in_w,
    parameter int gap      = 10,
    parameter int wgt_base = 1024,
    parameter int act_base = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        sfp_clr,
    output logic        sfp_valid,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx,
    output logic [2:0]  phase
);
    localparam int unsigned LEN_KIJ  = k * k;
    localparam int unsigned LEN_NIJ  = in_w * in_w;
    localparam int unsigned OW       = in_w - k + 1;
    localparam int unsigned LEN_ONIJ = OW * OW;
    localparam int unsigned E_WF     = nw;
    localparam int unsigned E_LD     = row + 3 * col - 1;
    localparam int unsigned E_GAP    = gap;
    localparam int unsigned E_L0     = na;
    localparam int unsigned E_EX     = na + row + col - 1;
    localparam int unsigned E_ACC    = LEN_KIJ + 2;
    localparam int unsigned A_WGT    = wgt_base + LEN_KIJ * nw;
    localparam int unsigned A_ACT    = act_base + na;
    localparam int unsigned A_PSUM   = LEN_KIJ * LEN_NIJ - 1;
    localparam int unsigned MAX_A    = (A_WGT > A_ACT ? A_WGT : A_ACT) > A_PSUM ?
                                       (A_WGT > A_ACT ? A_WGT : A_ACT) : A_PSUM;
    localparam logic [33:0] IDLE_W   = 34'h1_800C_0000;

    if (MAX_A > 2047) begin : g_addr_chk
        $error("core_inst_sequencer: address range exceeds 11 bits");
    end

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_WFIFO = 4'd1, S_LOAD = 4'd2, S_GAP = 4'd3, S_L0WR = 4'd4,
        S_EXEC = 4'd5, S_OFRD = 4'd6, S_ACC = 4'd7, S_DONE = 4'd8
    } state_t;

    state_t      state, nstate;
    int unsigned cnt, ncnt, kij, nkij, o, no, j;
    logic        fire, nfire, hs_ok;
    logic [33:0] w;

`ifdef SEQ_OFIFO_HANDSHAKE_EN
    assign hs_ok = ofifo_valid;
`else
    logic unused_ofifo_valid;
    assign unused_ofifo_valid = ofifo_valid;
    assign hs_ok = 1'b1;
`endif

    always_comb begin
        nstate = state;
        ncnt   = cnt + 1;
        nkij   = kij;
        no     = o;
        nfire  = 1'b0;
        case (state)
            S_IDLE: begin
                ncnt = 0;
                if (start) begin
                    nstate = S_WFIFO;
                    nkij   = 0;
                end
            end
            S_WFIFO: if (cnt == E_WF) begin nstate = S_LOAD; ncnt = 0; end
            S_LOAD:  if (cnt == E_LD) begin nstate = S_GAP;  ncnt = 0; end
            S_GAP:   if (cnt == E_GAP) begin nstate = S_L0WR; ncnt = 0; end
            S_L0WR:  if (cnt == E_L0) begin nstate = S_EXEC; ncnt = 0; end
            S_EXEC:  if (cnt == E_EX) begin nstate = S_OFRD; ncnt = 0; nfire = hs_ok; end
            S_OFRD: begin
                // cnt is the index of the current (or next pending) transfer
                ncnt  = fire ? cnt + 1 : cnt;
                nfire = hs_ok;
                if (fire && cnt == LEN_NIJ - 1) begin
                    ncnt  = 0;
                    nfire = 1'b0;
                    if (kij == LEN_KIJ - 1) begin
                        nstate = S_ACC;
                        no     = 0;
                    end else begin
                        nstate = S_WFIFO;
                        nkij   = kij + 1;
                    end
                end
            end
            S_ACC: if (cnt == E_ACC) begin
                ncnt = 0;
                if (o == LEN_ONIJ - 1) nstate = S_DONE;
                else no = o + 1;
            end
            default: begin nstate = S_IDLE; ncnt = 0; end
        endcase
    end

    // ACC cycle layout per output: 0 clear, 1..LEN_KIJ+1 for j=0..LEN_KIJ, then tail
    always_comb begin
        w = IDLE_W;
        j = ncnt - 1;
        case (nstate)
            S_WFIFO: begin
                w[19]   = 1'b0;
                w[5]    = 1'b1;
                w[17:7] = 11'(wgt_base + nkij * nw + ncnt);
            end
            S_LOAD: begin
                w[4] = 1'b1;
                w[0] = 1'b1;
            end
            S_L0WR: begin
                w[19]   = 1'b0;
                w[2]    = 1'b1;
                w[17:7] = 11'(act_base + ncnt);
            end
            S_EXEC: w[3:1] = 3'b111;
            S_OFRD: if (nfire) begin
                w[32:31] = 2'b00;
                w[6]     = 1'b1;
                w[30:20] = 11'(nkij * LEN_NIJ + ncnt);
            end
            S_ACC: begin
                w[33] = ncnt >= 2 && ncnt <= LEN_KIJ + 1;
                if (ncnt >= 1 && ncnt <= LEN_KIJ) begin
                    w[32]    = 1'b0;
                    w[30:20] = 11'(j * LEN_NIJ + (no / OW + j / k) * in_w + no % OW + j % k);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 0;
            kij       <= 0;
            o         <= 0;
            fire      <= 1'b0;
            inst      <= IDLE_W;
            sfp_clr   <= 1'b0;
            sfp_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            kij_idx   <= 4'd0;
            phase     <= 3'd0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            kij       <= nkij;
            o         <= no;
            fire      <= nfire;
            inst      <= w;
            sfp_clr   <= nstate == S_ACC && ncnt == 0;
            sfp_valid <= state == S_ACC && cnt == E_ACC;
            busy      <= nstate != S_IDLE;
            done      <= nstate == S_DONE;
            kij_idx   <= 4'(nkij);
            phase     <= nstate[2:0];
        end
    end
endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb_core_inst_sequencer: table-driven check of core_inst_sequencer with default parameters.
module tb_core_inst_sequencer;
    logic        clk = 1'b0, reset, start, ofifo_valid;
    logic [33:0] inst;
    logic        sfp_clr, sfp_valid, busy, done;
    logic [3:0]  kij_idx;
    logic [2:0]  phase;

    core_inst_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .sfp_clr(sfp_clr), .sfp_valid(sfp_valid), .busy(busy),
        .done(done), .kij_idx(kij_idx), .phase(phase)
    );

    always #5 clk = ~clk;

`ifdef SEQ_OFIFO_HANDSHAKE_EN
    localparam int OFRD_TOG = 72;
`else
    localparam int OFRD_TOG = 36;
`endif
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    localparam logic [33:0] ALL    = '1;
    localparam logic [33:0] NO_AP  = ~(34'h7FF << 20);
    localparam int ACC0 = 9 * 257;
    localparam int DONE_C = ACC0 + 16 * 12;
    localparam int NCAP = 2510;

    typedef struct {
        int          cyc;
        logic [33:0] msk;
        logic [33:0] w;
        logic [2:0]  ph;
        logic [3:0]  kij;
    } vec_t;

    vec_t        tbl[33];
    int          acc_a[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
    int          vecs = 0, errs = 0;
    logic [33:0] t_inst[NCAP];
    logic [2:0]  t_ph[NCAP];
    logic [3:0]  t_kij[NCAP];
    logic        t_busy[NCAP], t_done[NCAP], t_clr[NCAP], t_val[NCAP];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input bit acc, input bit cp, input bit wp, input int ap,
                                       input bit cx, input bit wx, input int ax, input logic [6:0] lo);
        return {acc, cp, wp, 11'(ap), cx, wx, 11'(ax), lo};
    endfunction

    function automatic logic [2:0] ph_of(input int c);
        int r;
        if (c >= DONE_C) return 3'd0;
        if (c >= ACC0) return 3'd7;
        r = c % 257;
        return r < 17 ? 3'd1 : r < 49 ? 3'd2 : r < 60 ? 3'd3 : r < 133 ? 3'd4 : r < 221 ? 3'd5 : 3'd6;
    endfunction

    task automatic run(input int n, input bit tog);
        start       = 1'b1;
        ofifo_valid = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            t_inst[c] = inst; t_ph[c] = phase; t_kij[c] = kij_idx;
            t_busy[c] = busy; t_done[c] = done; t_clr[c] = sfp_clr; t_val[c] = sfp_valid;
            start       = (c == 100);
            ofifo_valid = tog ? c[0] : 1'b1;
        end
    endtask

    initial begin
        tbl[0]  = '{0,    ALL, mk(0, 1, 1, 0, 0, 1, 1024, 7'h20), 3'd1, 4'd0};
        tbl[1]  = '{16,   ALL, mk(0, 1, 1, 0, 0, 1, 1040, 7'h20), 3'd1, 4'd0};
        tbl[2]  = '{17,   ALL, mk(0, 1, 1, 0, 1, 1, 0, 7'h11),    3'd2, 4'd0};
        tbl[3]  = '{48,   ALL, mk(0, 1, 1, 0, 1, 1, 0, 7'h11),    3'd2, 4'd0};
        tbl[4]  = '{49,   ALL, IDLE_W,                            3'd3, 4'd0};
        tbl[5]  = '{59,   ALL, IDLE_W,                            3'd3, 4'd0};
        tbl[6]  = '{60,   ALL, mk(0, 1, 1, 0, 0, 1, 0, 7'h04),    3'd4, 4'd0};
        tbl[7]  = '{132,  ALL, mk(0, 1, 1, 0, 0, 1, 72, 7'h04),   3'd4, 4'd0};
        tbl[8]  = '{133,  ALL, mk(0, 1, 1, 0, 1, 1, 0, 7'h0E),    3'd5, 4'd0};
        tbl[9]  = '{220,  ALL, mk(0, 1, 1, 0, 1, 1, 0, 7'h0E),    3'd5, 4'd0};
        tbl[10] = '{221,  ALL, mk(0, 0, 0, 0, 1, 1, 0, 7'h40),    3'd6, 4'd0};
        tbl[11] = '{256,  ALL, mk(0, 0, 0, 35, 1, 1, 0, 7'h40),   3'd6, 4'd0};
        tbl[12] = '{257,  ALL, mk(0, 1, 1, 0, 0, 1, 1040, 7'h20), 3'd1, 4'd1};
        tbl[13] = '{514,  ALL, mk(0, 1, 1, 0, 0, 1, 1056, 7'h20), 3'd1, 4'd2};
        tbl[14] = '{530,  ALL, mk(0, 1, 1, 0, 0, 1, 1072, 7'h20), 3'd1, 4'd2};
        tbl[15] = '{992,  ALL, mk(0, 0, 0, 108, 1, 1, 0, 7'h40),  3'd6, 4'd3};
        tbl[16] = '{1027, ALL, mk(0, 0, 0, 143, 1, 1, 0, 7'h40),  3'd6, 4'd3};
        tbl[17] = '{2277, ALL, mk(0, 0, 0, 288, 1, 1, 0, 7'h40),  3'd6, 4'd8};
        tbl[18] = '{2312, ALL, mk(0, 0, 0, 323, 1, 1, 0, 7'h40),  3'd6, 4'd8};
        tbl[19] = '{ACC0, ALL, IDLE_W,                            3'd7, 4'd8};
        for (int i = 0; i < 9; i++)
            tbl[20 + i] = '{ACC0 + 61 + i, ALL, mk(i > 0, 0, 1, acc_a[i], 1, 1, 0, 7'h00), 3'd7, 4'd8};
        tbl[29] = '{ACC0 + 70, NO_AP, mk(1, 1, 1, 0, 1, 1, 0, 7'h00), 3'd7, 4'd8};
        tbl[30] = '{ACC0 + 71, ALL, IDLE_W,                       3'd7, 4'd8};
        tbl[31] = '{DONE_C,    ALL, IDLE_W,                       3'd0, 4'd8};
        tbl[32] = '{DONE_C + 1, ALL, IDLE_W,                      3'd0, 4'd8};

        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst inst", inst, IDLE_W);
        chk("rst busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle inst", inst, IDLE_W);
        chk("idle flags", {busy, done, sfp_clr, sfp_valid}, 0);
        chk("idle phase/kij", {phase, kij_idx}, 0);

        run(NCAP, 1'b0);
        foreach (tbl[i]) begin
            chk($sformatf("vec%0d@%0d inst", i, tbl[i].cyc), t_inst[tbl[i].cyc] & tbl[i].msk, tbl[i].w & tbl[i].msk);
            chk($sformatf("vec%0d@%0d phase", i, tbl[i].cyc), t_ph[tbl[i].cyc], tbl[i].ph);
            if (tbl[i].cyc < ACC0)
                chk($sformatf("vec%0d@%0d kij", i, tbl[i].cyc), t_kij[tbl[i].cyc], tbl[i].kij);
        end
        begin
            int bp = 0, bb = 0, bd = 0, bc = 0, bv = 0, nv = 0;
            for (int c = 0; c <= DONE_C + 1; c++) begin
                bp += int'(t_ph[c] != ph_of(c));
                bb += int'(t_busy[c] != (c <= DONE_C));
                bd += int'(t_done[c] != (c == DONE_C));
                bc += int'(t_clr[c] != (c >= ACC0 && c < DONE_C && (c - ACC0) % 12 == 0));
                bv += int'(t_val[c] != (c > ACC0 && c <= DONE_C && (c - ACC0) % 12 == 0));
                nv += int'(t_val[c]);
            end
            chk("phase trace bad cycles", bp, 0);
            chk("busy trace bad cycles", bb, 0);
            chk("done trace bad cycles", bd, 0);
            chk("sfp_clr trace bad cycles", bc, 0);
            chk("sfp_valid trace bad cycles", bv, 0);
            chk("sfp_valid pulses", nv, 16);
        end

        // ofifo_valid alternates: stalls OFRD only when the handshake is built in
        run(300, 1'b1);
        begin
            int nof = 0, nwr = 0, bad = 0;
            for (int c = 0; c < 300; c++) if (t_ph[c] == 3'd6) begin
                nof++;
                if (t_inst[c][32] == 1'b0) begin
                    bad += int'(t_inst[c][30:20] != 11'(nwr));
                    nwr++;
                end
            end
            chk("ofrd cycles", nof, OFRD_TOG);
            chk("ofrd writes", nwr, 36);
            chk("ofrd addr seq bad", bad, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        run(151, 1'b0);
        chk("pre-abort phase", t_ph[150], 3'd5);
        reset = 1'b1;
        @(negedge clk);
        chk("abort inst", inst, IDLE_W);
        chk("abort phase/kij", {phase, kij_idx}, 0);
        chk("abort flags", {busy, done, sfp_clr, sfp_valid}, 0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
